// File: rtl/library_checker_pkg.sv
// Shared encodings and helpers for the cell-library response checker.
package library_checker_pkg;

   // Width of the per-sample expected/observed/mismatch vectors
   localparam int unsigned VEC_W = 6;

   // Bit positions inside the expected/observed/mismatch vectors
   localparam int unsigned NAND_BIT = 0;
   localparam int unsigned NOR_BIT  = 1;
   localparam int unsigned NOT_BIT  = 2;
   localparam int unsigned MUX_BIT  = 3;
   localparam int unsigned QP_BIT   = 4;
   localparam int unsigned QN_BIT   = 5;

   // Checker run-control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Gated 2:1 mux reference: output forced low while disabled
   function automatic logic mux_expect(input logic a, input logic b,
                                       input logic sel, input logic enb);
      return enb & (sel ? b : a);
   endfunction

endpackage

// File: rtl/lib_golden_model.sv
// Golden reference for the library cells: combinational expectations plus
// a shadow flop that tracks the ffd stimulus.
module lib_golden_model
   import library_checker_pkg::*;
(
   input  logic             iClk,
   input  logic             iClr,
   input  logic             iA,
   input  logic             iB,
   input  logic             iD,
   input  logic             iSel,
   input  logic             iEnb,
   input  logic             iDutClr,
   input  logic             iDutPre,
   output logic [VEC_W-1:0] oExpVec_c,
   output logic             oQValid
);

   logic expq;
   logic exp_qp_c;

   // Expected output of every cell for the stimulus currently applied
   always_comb begin
      oExpVec_c = '0;
      exp_qp_c  = iDutClr ? 1'b0 : (iDutPre ? 1'b1 : expq);
      oExpVec_c[NAND_BIT] = ~(iA & iB);
      oExpVec_c[NOR_BIT]  = ~(iA | iB);
      oExpVec_c[NOT_BIT]  = ~iA;
      oExpVec_c[MUX_BIT]  = mux_expect(iA, iB, iSel, iEnb);
      oExpVec_c[QP_BIT]   = exp_qp_c;
      oExpVec_c[QN_BIT]   = ~exp_qp_c;
   end

   // Shadow flop: clear beats preset; becomes valid after its first edge
   always_ff @(posedge iClk or posedge iClr) begin
      if (iClr) begin
         expq    <= 1'b0;
         oQValid <= 1'b0;
      end else begin
         oQValid <= 1'b1;
         if (iDutClr) begin
            expq <= 1'b0;
         end else if (iDutPre) begin
            expq <= 1'b1;
         end else begin
            expq <= iD;
         end
      end
   end

endmodule

// File: rtl/library_checker.sv
// Response checker for the cell-library tester: compares cell outputs with
// the golden model, counts samples/errors and latches the first failure.
module library_checker
   import library_checker_pkg::*;
#(
   parameter int unsigned NUM_SAMPLES = 256,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned ERR_W       = 8,
   parameter logic [5:0]  CHECK_MASK  = 6'b111111
)
(
   input  logic             iClk,
   input  logic             iClr,
   input  logic             iStart,
   input  logic             iStop,
   input  logic             iA,
   input  logic             iB,
   input  logic             iD,
   input  logic             iSel,
   input  logic             iEnb,
   input  logic             iDutClr,
   input  logic             iDutPre,
   input  logic             iNand,
   input  logic             iNor,
   input  logic             iNot,
   input  logic             iMux,
   input  logic             iQp,
   input  logic             iQn,
   output logic             oBusy,
   output logic             oDone,
   output logic             oPass,
   output logic [ERR_W-1:0] oErrCnt,
   output logic [CNT_W-1:0] oSampleCnt,
   output logic [VEC_W-1:0] oFirstErrVec,
   output logic [CNT_W-1:0] oFirstErrIdx
);

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   samp_d;
   logic [ERR_W-1:0]   err_d;
   logic [VEC_W-1:0]   fvec_d;
   logic [CNT_W-1:0]   fidx_d;
   logic               busy_d;
   logic               done_d;
   logic               pass_d;

   logic [VEC_W-1:0]   exp_c;
   logic               qvalid;
   logic [VEC_W-1:0]   obs_c;
   logic [VEC_W-1:0]   chk_mask_c;
   logic [VEC_W-1:0]   mism_c;
   logic               qchk_c;
   logic               err_sat_c;
   logic               last_c;

   lib_golden_model u_golden (
      .iClk      (iClk),
      .iClr      (iClr),
      .iA        (iA),
      .iB        (iB),
      .iD        (iD),
      .iSel      (iSel),
      .iEnb      (iEnb),
      .iDutClr   (iDutClr),
      .iDutPre   (iDutPre),
      .oExpVec_c (exp_c),
      .oQValid   (qvalid)
   );

   // Per-output mismatch; X/Z on a checked output is a mismatch
   always_comb begin
      obs_c      = '0;
      obs_c[NAND_BIT] = iNand;
      obs_c[NOR_BIT]  = iNor;
      obs_c[NOT_BIT]  = iNot;
      obs_c[MUX_BIT]  = iMux;
      obs_c[QP_BIT]   = iQp;
      obs_c[QN_BIT]   = iQn;
      // Flop outputs are only meaningful once the shadow flop has state,
      // or when clear/preset forces a known value this cycle.
      qchk_c     = qvalid | iDutClr | iDutPre;
      chk_mask_c = CHECK_MASK;
      if (!qchk_c) begin
         chk_mask_c[QP_BIT] = 1'b0;
         chk_mask_c[QN_BIT] = 1'b0;
      end
      mism_c = '0;
      for (int i = 0; i < int'(VEC_W); i++) begin
         mism_c[i] = (obs_c[i] !== exp_c[i]) && chk_mask_c[i];
      end
      err_sat_c = (oErrCnt == {ERR_W{1'b1}});
      last_c    = (oSampleCnt == CNT_W'(NUM_SAMPLES - 1));
   end

   // Next state, next counters and next status flags
   always_comb begin
      state_d = state_q;
      samp_d  = oSampleCnt;
      err_d   = oErrCnt;
      fvec_d  = oFirstErrVec;
      fidx_d  = oFirstErrIdx;
      case (state_q)
         IDLE, DONE: begin
            if (iStart) begin
               state_d = RUN;
               samp_d  = '0;
               err_d   = '0;
               fvec_d  = '0;
               fidx_d  = '0;
            end
         end
         RUN: begin
            samp_d = oSampleCnt + CNT_W'(1);
            if (|mism_c) begin
               if (!err_sat_c) begin
                  err_d = oErrCnt + ERR_W'(1);
               end
               if (oErrCnt == '0) begin
                  fvec_d = mism_c;
                  fidx_d = oSampleCnt;
               end
            end
            if (iStop || last_c) begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
      pass_d = done_d && (err_d == '0);
   end

   // State and registered outputs
   always_ff @(posedge iClk or posedge iClr) begin
      if (iClr) begin
         state_q      <= IDLE;
         oBusy        <= 1'b0;
         oDone        <= 1'b0;
         oPass        <= 1'b0;
         oErrCnt      <= '0;
         oSampleCnt   <= '0;
         oFirstErrVec <= '0;
         oFirstErrIdx <= '0;
      end else begin
         state_q      <= state_d;
         oBusy        <= busy_d;
         oDone        <= done_d;
         oPass        <= pass_d;
         oErrCnt      <= err_d;
         oSampleCnt   <= samp_d;
         oFirstErrVec <= fvec_d;
         oFirstErrIdx <= fidx_d;
      end
   end

endmodule

// File: tb/tb_library_checker.sv
// Randomized and directed bench for library_checker against a behavioural model.
module tb_library_checker;

   localparam int unsigned NS   = 300;
   localparam int unsigned CW   = 16;
   localparam int unsigned EW   = 8;
   localparam logic [5:0]  MASK = 6'b111111;
   localparam int          ERR_MAX = (1 << EW) - 1;

   logic iClk = 1'b0;
   logic iClr = 1'b1;
   logic iStart = 1'b0, iStop = 1'b0;
   logic iA = 1'b0, iB = 1'b0, iD = 1'b0, iSel = 1'b0, iEnb = 1'b0;
   logic iDutClr = 1'b0, iDutPre = 1'b0;
   logic iNand = 1'b1, iNor = 1'b1, iNot = 1'b1, iMux = 1'b0, iQp = 1'b0, iQn = 1'b1;
   logic          oBusy, oDone, oPass;
   logic [EW-1:0] oErrCnt;
   logic [CW-1:0] oSampleCnt;
   logic [5:0]    oFirstErrVec;
   logic [CW-1:0] oFirstErrIdx;

   int n_vec = 0;
   int n_bad = 0;

   always #5 iClk = ~iClk;

   library_checker #(
      .NUM_SAMPLES(NS), .CNT_W(CW), .ERR_W(EW), .CHECK_MASK(MASK)
   ) dut (
      .iClk(iClk), .iClr(iClr), .iStart(iStart), .iStop(iStop),
      .iA(iA), .iB(iB), .iD(iD), .iSel(iSel), .iEnb(iEnb),
      .iDutClr(iDutClr), .iDutPre(iDutPre),
      .iNand(iNand), .iNor(iNor), .iNot(iNot), .iMux(iMux), .iQp(iQp), .iQn(iQn),
      .oBusy(oBusy), .oDone(oDone), .oPass(oPass), .oErrCnt(oErrCnt),
      .oSampleCnt(oSampleCnt), .oFirstErrVec(oFirstErrVec), .oFirstErrIdx(oFirstErrIdx)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit         m_run, m_done, m_seen, m_qv, m_q;
   int         m_samp, m_err, m_fidx;
   bit [5:0]   m_fvec;
   bit [5:0]   m_exp, m_obs, m_mis;
   bit         m_qp, m_qchk;

   always @(posedge iClk or posedge iClr) begin
      if (iClr) begin
         m_run = 0; m_done = 0; m_seen = 0; m_qv = 0; m_q = 0;
         m_samp = 0; m_err = 0; m_fidx = 0; m_fvec = 0;
      end else begin
         m_qp   = iDutClr ? 1'b0 : (iDutPre ? 1'b1 : m_q);
         m_exp  = {~m_qp, m_qp, iEnb & (iSel ? iB : iA), ~iA, ~(iA | iB), ~(iA & iB)};
         m_obs  = {iQn, iQp, iMux, iNot, iNor, iNand};
         m_qchk = m_qv | iDutClr | iDutPre;
         m_mis  = (m_obs ^ m_exp) & MASK & {m_qchk, m_qchk, 4'hf};
         if (m_run) begin
            if (m_mis != 6'd0) begin
               if (!m_seen) begin
                  m_seen = 1; m_fvec = m_mis; m_fidx = m_samp;
               end
               if (m_err < ERR_MAX) m_err++;
            end
            m_samp++;
            if (iStop || m_samp == int'(NS)) begin
               m_run = 0; m_done = 1;
            end
         end else if (iStart) begin
            m_run = 1; m_done = 0; m_seen = 0;
            m_samp = 0; m_err = 0; m_fidx = 0; m_fvec = 0;
         end
         m_q  = iDutClr ? 1'b0 : (iDutPre ? 1'b1 : iD);
         m_qv = 1;
      end
   end

   // Compare every output against the model each cycle
   always @(negedge iClk) begin
      chk("busy",  32'(oBusy),        32'(m_run));
      chk("done",  32'(oDone),        32'(m_done));
      chk("pass",  32'(oPass),        32'(m_done && m_err == 0));
      chk("errcnt", 32'(oErrCnt),     32'(m_err));
      chk("sampcnt", 32'(oSampleCnt), 32'(m_samp));
      chk("fvec",  32'(oFirstErrVec), 32'(m_fvec));
      chk("fidx",  32'(oFirstErrIdx), 32'(m_fidx));
   end

   // ---------------- stimulus ----------------
   bit c_q;  // state of the emulated flop under test

   task automatic drive(input bit a, input bit b, input bit d, input bit sel,
                        input bit enb, input bit clr, input bit pre,
                        input bit [5:0] flip, input bit start, input bit stop);
      bit qp;
      @(posedge iClk);
      #3;
      c_q = iDutClr ? 1'b0 : (iDutPre ? 1'b1 : iD);
      iA = a; iB = b; iD = d; iSel = sel; iEnb = enb;
      iDutClr = clr; iDutPre = pre; iStart = start; iStop = stop;
      qp    = clr ? 1'b0 : (pre ? 1'b1 : c_q);
      iNand = ~(a & b) ^ flip[0];
      iNor  = ~(a | b) ^ flip[1];
      iNot  = ~a ^ flip[2];
      iMux  = (enb & (sel ? b : a)) ^ flip[3];
      iQp   = qp ^ flip[4];
      iQn   = ~qp ^ flip[5];
   endtask

   task automatic healthy(input int i, input bit [5:0] flip, input bit start, input bit stop);
      drive(i[0], i[1], i[0] ^ i[4], i[2], i[3], 1'b0, 1'b0, flip, start, stop);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0);
   endtask

   task automatic lit_all(input string tag, input bit busy, input bit done, input bit pass,
                          input int samp, input int err, input bit [5:0] vec, input int idx);
      @(negedge iClk);
      chk({tag, "_busy"}, 32'(oBusy), 32'(busy));
      chk({tag, "_done"}, 32'(oDone), 32'(done));
      chk({tag, "_pass"}, 32'(oPass), 32'(pass));
      chk({tag, "_samp"}, 32'(oSampleCnt), 32'(samp));
      chk({tag, "_err"},  32'(oErrCnt), 32'(err));
      chk({tag, "_vec"},  32'(oFirstErrVec), 32'(vec));
      chk({tag, "_idx"},  32'(oFirstErrIdx), 32'(idx));
   endtask

   initial begin
      int len;
      bit [9:0] rv;
      bit [5:0] fl;
      c_q = 1'($urandom);
      repeat (2) @(posedge iClk);
      lit_all("reset", 0, 0, 0, 0, 0, 6'd0, 0);
      iClr = 1'b0;

      // healthy exhaustive sweep, 16 samples
      healthy(0, 6'd0, 1, 0);
      for (int i = 0; i < 16; i++) healthy(i, 6'd0, 0, i == 15);
      idle();
      lit_all("sweep", 0, 1, 1, 16, 0, 6'd0, 0);

      // single nand failure at sample 5
      healthy(0, 6'd0, 1, 0);
      for (int i = 0; i < 8; i++) healthy(i, (i == 5) ? 6'b000001 : 6'd0, 0, i == 7);
      idle();
      lit_all("nand5", 0, 1, 0, 8, 1, 6'b000001, 5);

      // clear and preset together: observed Qp=1 fails, Qp=0 passes
      healthy(0, 6'd0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         if (i == 1)      drive(1, 0, 1, 0, 1, 1, 1, 6'b110000, 0, 0);
         else if (i == 2) drive(1, 0, 1, 0, 1, 1, 1, 6'd0, 0, 0);
         else             healthy(i, 6'd0, 0, i == 3);
      end
      idle();
      lit_all("clrpre", 0, 1, 0, 4, 1, 6'b110000, 1);

      // mux error at sample 1, stop together with start at sample 3
      healthy(0, 6'd0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         if (i == 1) drive(1, 1, 0, 1, 0, 0, 0, 6'b001000, 0, 0);
         else        healthy(i, 6'd0, i == 3, i == 3);
      end
      idle();
      lit_all("stop3", 0, 1, 0, 4, 1, 6'b001000, 1);
      // start and stop together in DONE restarts the run
      healthy(0, 6'd0, 1, 1);
      idle();
      lit_all("restart", 1, 0, 0, 0, 0, 6'd0, 0);
      healthy(3, 6'd0, 0, 1);
      idle();

      // 300 consecutive not failures: auto-finish with saturated count
      healthy(0, 6'd0, 1, 0);
      for (int i = 0; i < int'(NS); i++) healthy(i, 6'b000100, 0, 0);
      idle();
      lit_all("sat", 0, 1, 0, 300, 255, 6'b000100, 0);

      // reset in the middle of a run, then a clean run
      healthy(0, 6'd0, 1, 0);
      for (int i = 0; i < 8; i++) healthy(i, 6'd0, 0, 0);
      #1 iClr = 1'b1;
      lit_all("midclr", 0, 0, 0, 0, 0, 6'd0, 0);
      iClr = 1'b0;
      healthy(0, 6'd0, 1, 0);
      for (int i = 0; i < 20; i++) healthy(i, 6'd0, 0, i == 19);
      idle();
      lit_all("postclr", 0, 1, 1, 20, 0, 6'd0, 0);

      // randomized runs with sparse faults, glitches and occasional reset
      for (int r = 0; r < 30; r++) begin
         len = $urandom_range(40, 1);
         healthy(0, 6'd0, 1, 0);
         for (int i = 0; i < len; i++) begin
            rv = 10'($urandom);
            fl = (rv[9:7] == 3'd0) ? 6'(1 << $urandom_range(5, 0)) : 6'd0;
            drive(rv[0], rv[1], rv[2], rv[3], rv[4], rv[6:5] == 2'b11, rv[8] & rv[4],
                  fl, rv[9:8] == 2'b11, i == len - 1);
            if ($urandom_range(150, 0) == 0) begin
               #1 iClr = 1'b1;
               @(negedge iClk);
               iClr = 1'b0;
            end
         end
         idle();
         idle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

endmodule
